// File: rtl/pmau_feeder.sv
// Sequencer for the PMAU input side: buffers up to MAX_BEATS rows of A/X lanes,
// streams them as a framed burst on START, then captures Y onto a valid/ready port.
module pmau_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BEATS  = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    LD_en,
  input  logic [2:0]              LD_addr,
  input  logic [8*DATA_WIDTH-1:0] LD_A,
  input  logic [8*DATA_WIDTH-1:0] LD_X,
  input  logic                    START,
  input  logic [3:0]              LEN,
  output logic                    BUSY,
  output logic [8*DATA_WIDTH-1:0] A_out,
  output logic [8*DATA_WIDTH-1:0] X_out,
  output logic                    A_valid,
  output logic                    X_valid,
  output logic                    First_Row,
  output logic                    Last_Row,
  input  logic [DATA_WIDTH-1:0]   Y_in,
  input  logic                    Y_valid_in,
  output logic [DATA_WIDTH-1:0]   RES_data,
  output logic                    RES_valid,
  input  logic                    RES_ready,
  output logic                    ERR
);

  localparam int LW = 8 * DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    MAX_LEN  = 4'(MAX_BEATS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t          state;
  logic [3:0]      len_q;
  logic [2:0]      beat_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [LW-1:0]   buf_a [MAX_BEATS];
  logic [LW-1:0]   buf_x [MAX_BEATS];
  logic            len_ok;
  logic            last_beat;

  assign len_ok    = (LEN != 4'd0) && (LEN <= MAX_LEN);
  assign last_beat = ({1'b0, beat_cnt} == (len_q - 4'd1));
  assign BUSY      = (state != IDLE);
  assign X_valid   = A_valid;

  // Beat buffer holds data only; it survives reset so a run can be repeated.
  always_ff @(posedge CLK) begin
    if (state == IDLE && LD_en) begin
      buf_a[LD_addr] <= LD_A;
      buf_x[LD_addr] <= LD_X;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      len_q     <= 4'd0;
      beat_cnt  <= 3'd0;
      tmo_cnt   <= '0;
      A_out     <= '0;
      X_out     <= '0;
      A_valid   <= 1'b0;
      First_Row <= 1'b0;
      Last_Row  <= 1'b0;
      RES_data  <= '0;
      RES_valid <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      // PMAU-side outputs are zero on every cycle that does not carry a beat.
      ERR       <= 1'b0;
      A_valid   <= 1'b0;
      A_out     <= '0;
      X_out     <= '0;
      First_Row <= 1'b0;
      Last_Row  <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (len_ok) begin
              len_q    <= LEN;
              beat_cnt <= 3'd0;
              state    <= ISSUE;
            end else begin
              ERR <= 1'b1;
            end
          end
        end
        ISSUE: begin
          A_valid   <= 1'b1;
          A_out     <= buf_a[beat_cnt];
          X_out     <= buf_x[beat_cnt];
          First_Row <= (beat_cnt == 3'd0);
          Last_Row  <= last_beat;
          beat_cnt  <= beat_cnt + 3'd1;
          if (last_beat) begin
            tmo_cnt <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // A result arriving on the final timeout cycle still wins.
          if (Y_valid_in) begin
            RES_data  <= Y_in;
            RES_valid <= 1'b1;
            state     <= HOLD;
          end else if (tmo_cnt == TMO_LAST) begin
            ERR   <= 1'b1;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        HOLD: begin
          if (RES_ready) begin
            RES_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
